// File: rtl/miriscv_mem_arbiter_if.sv
// Bus bundle between the fetch unit, the load/store unit, the arbiter and the shared memory port.
// Handshake: a requester holds req (and its fields) until its rvalid pulse, except fetch, which may
// drop req to abandon; mem_req_o holds its fields until the mem_gnt_i cycle; each grant is answered
// by exactly one single-cycle mem_rvalid_i at least one cycle after the grant.
interface miriscv_mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic              instr_req_i;
  logic [XLEN-1:0]   instr_addr_i;
  logic              instr_rvalid_o;
  logic [XLEN-1:0]   instr_rdata_o;
  logic              data_req_i;
  logic              data_we_i;
  logic [XLEN/8-1:0] data_be_i;
  logic [XLEN-1:0]   data_addr_i;
  logic [XLEN-1:0]   data_wdata_i;
  logic              data_rvalid_o;
  logic [XLEN-1:0]   data_rdata_o;
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic              mem_we_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;

  // Arbiter side
  modport slave (
    input  instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output instr_rvalid_o, instr_rdata_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  // Requesters plus memory side
  modport master (
    output instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  instr_rvalid_o, instr_rdata_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/miriscv_mem_arbiter.sv
// Shares one single-ported memory between fetch and LSU: one outstanding transaction at a time,
// response routed to its owner, abandoned fetch responses dropped.
module miriscv_mem_arbiter #(
  parameter int XLEN      = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  miriscv_mem_arbiter_if.slave  bus,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;     // 1 = data, 0 = instr
  logic              discard_q, discard_d;
  logic              last_q, last_d;       // last served: 1 = data, 0 = instr
  logic              we_q, we_d;
  logic [XLEN/8-1:0] be_q, be_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              pick_data;
  logic              mem_req;
  logic              instr_rvalid;
  logic              data_rvalid;

  // Round-robin only matters on contention: data wins unless it was served last.
  assign pick_data = bus.data_req_i & ((PRIO_MODE == 0) | ~bus.instr_req_i | ~last_q);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      discard_q <= 1'b0;
      last_q    <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      discard_q <= discard_d;
      last_q    <= last_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    discard_d    = discard_q;
    last_d       = last_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_req      = 1'b0;
    instr_rvalid = 1'b0;
    data_rvalid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_req_i || bus.data_req_i) begin
          owner_d   = pick_data;
          discard_d = 1'b0;
          state_d   = S_REQ;
          if (pick_data) begin
            we_d    = bus.data_we_i;
            be_d    = bus.data_be_i;
            addr_d  = bus.data_addr_i;
            wdata_d = bus.data_wdata_i;
          end else begin
            we_d    = 1'b0;
            be_d    = '1;
            addr_d  = bus.instr_addr_i;
            wdata_d = '0;
          end
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (bus.mem_gnt_i) begin
          state_d = S_WAIT;
          last_d  = owner_q;
          if (!owner_q && !bus.instr_req_i) discard_d = 1'b1;
        end else if (!owner_q && !bus.instr_req_i) begin
          // Fetch gave up before the memory accepted: nothing was issued.
          state_d = S_IDLE;
          owner_d = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      S_WAIT: begin
        if (!owner_q && !bus.instr_req_i) discard_d = 1'b1;
        if (bus.mem_rvalid_i) begin
          data_rvalid  = owner_q;
          instr_rvalid = !owner_q && !discard_q && bus.instr_req_i;
          state_d      = S_IDLE;
          owner_d      = 1'b0;
          discard_d    = 1'b0;
          we_d         = 1'b0;
          be_d         = '0;
          addr_d       = '0;
          wdata_d      = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_req_o      = mem_req;
  assign bus.mem_we_o       = we_q;
  assign bus.mem_be_o       = be_q;
  assign bus.mem_addr_o     = addr_q;
  assign bus.mem_wdata_o    = wdata_q;
  assign bus.instr_rvalid_o = instr_rvalid;
  assign bus.instr_rdata_o  = instr_rvalid ? bus.mem_rdata_i : '0;
  assign bus.data_rvalid_o  = data_rvalid;
  assign bus.data_rdata_o   = data_rvalid ? bus.mem_rdata_i : '0;
  assign state_o            = state_q;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed bench: per-cycle vector table for plain and contended transfers, hand sequences for
// abort, discard and reset corner cases, and a round-robin run on a second instance.
module tb_miriscv_mem_arbiter;
  localparam int XLEN = 32;

  logic       clk;
  logic       arstn;
  logic [1:0] state0, state1;
  int         checks;
  int         failures;

  miriscv_mem_arbiter_if #(.XLEN(XLEN)) bus0 ();
  miriscv_mem_arbiter_if #(.XLEN(XLEN)) bus1 ();

  miriscv_mem_arbiter #(.XLEN(XLEN), .PRIO_MODE(0)) dut0 (
    .clk_i(clk), .arstn_i(arstn), .bus(bus0), .state_o(state0)
  );
  miriscv_mem_arbiter #(.XLEN(XLEN), .PRIO_MODE(1)) dut1 (
    .clk_i(clk), .arstn_i(arstn), .bus(bus1), .state_o(state1)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq, input logic dwe,
                       input logic [3:0] dbe, input logic [31:0] daddr, input logic [31:0] dwdata,
                       input logic gnt, input logic rvalid, input logic [31:0] rdata);
    bus0.instr_req_i  = ireq;
    bus0.instr_addr_i = iaddr;
    bus0.data_req_i   = dreq;
    bus0.data_we_i    = dwe;
    bus0.data_be_i    = dbe;
    bus0.data_addr_i  = daddr;
    bus0.data_wdata_i = dwdata;
    bus0.mem_gnt_i    = gnt;
    bus0.mem_rvalid_i = rvalid;
    bus0.mem_rdata_i  = rdata;
  endtask

  task automatic idle0();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  typedef struct {
    logic ireq; logic [31:0] iaddr; logic dreq; logic dwe; logic [3:0] dbe;
    logic [31:0] daddr; logic [31:0] dwdata; logic gnt; logic rvalid; logic [31:0] rdata;
    logic mreq; logic mwe; logic [3:0] mbe; logic [31:0] maddr; logic [31:0] mwdata;
    logic irv; logic [31:0] irdata; logic drv; logic [31:0] drdata;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  // ---------------- round-robin scoreboard (instance 1) ----------------
  logic            rr_run;
  int              rr_issues;
  logic [XLEN-1:0] exp_q [$];

  initial begin
    int cnt;
    cnt = 0;
    rr_run = 1'b0;
    rr_issues = 0;
    bus1.instr_req_i  = 1'b0;
    bus1.instr_addr_i = 32'h1000;
    bus1.data_req_i   = 1'b0;
    bus1.data_we_i    = 1'b0;
    bus1.data_be_i    = 4'hF;
    bus1.data_addr_i  = 32'h2000;
    bus1.data_wdata_i = 32'h0;
    bus1.mem_gnt_i    = 1'b0;
    bus1.mem_rvalid_i = 1'b0;
    bus1.mem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      bus1.instr_req_i  = rr_run;
      bus1.data_req_i   = rr_run;
      bus1.mem_gnt_i    = 1'b0;
      bus1.mem_rvalid_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus1.mem_rvalid_i = 1'b1;
          bus1.mem_rdata_i  = 32'h5500_0000;
        end
      end else if (bus1.mem_req_o) begin
        bus1.mem_gnt_i = 1'b1;
        cnt = 2;
        rr_issues++;
        if (exp_q.size() == 0) begin
          chk("rr_extra_issue", 64'(bus1.mem_addr_o), 64'hFFFF_FFFF);
        end else begin
          chk("rr_order", 64'(bus1.mem_addr_o), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [135:0] act, exp;
    checks = 0;
    failures = 0;

    vecs[0]  = '{1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                 1'b1, 1'b0, 4'hF, 32'h80, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 4'hF, 32'h80, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h13,
                 1'b0, 1'b0, 4'hF, 32'h80, 32'h0, 1'b1, 32'h13, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h100, 1'b1, 1'b1, 4'hF, 32'h200, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h100, 1'b1, 1'b1, 4'hF, 32'h200, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,
                 1'b1, 1'b1, 4'hF, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h100, 1'b1, 1'b1, 4'hF, 32'h200, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b1, 4'hF, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h100, 1'b1, 1'b1, 4'hF, 32'h200, 32'hDEADBEEF, 1'b0, 1'b1, 32'h5A5A,
                 1'b0, 1'b1, 4'hF, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 32'h5A5A};
    vecs[9]  = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE0001,
                 1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b1, 32'hCAFE0001, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};

    // Reset state
    arstn = 1'b0;
    drive(1'b1, 32'h44, 1'b1, 1'b1, 4'hF, 32'h88, 32'h1, 1'b1, 1'b1, 32'h77);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 64'(state0), 64'd0);
    chk("rst_mem_req", 64'(bus0.mem_req_o), 64'd0);
    chk("rst_mem_fields", {bus0.mem_we_o, bus0.mem_be_o, bus0.mem_addr_o}, 64'd0);
    chk("rst_mem_wdata", 64'(bus0.mem_wdata_o), 64'd0);
    chk("rst_rvalids", {bus0.instr_rvalid_o, bus0.data_rvalid_o}, 64'd0);
    chk("rst_rdata", {bus0.instr_rdata_o, bus0.data_rdata_o}, 64'd0);
    chk("rst_state_rr", 64'(state1), 64'd0);
    idle0();
    next_cyc();
    arstn = 1'b1;
    next_cyc();

    // Vector table: instr-only transfer, then contended transfer with data priority
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe, vecs[i].dbe, vecs[i].daddr,
            vecs[i].dwdata, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
      @(negedge clk);
      act = {bus0.mem_req_o, bus0.mem_we_o, bus0.mem_be_o, bus0.mem_addr_o, bus0.mem_wdata_o,
             bus0.instr_rvalid_o, bus0.instr_rdata_o, bus0.data_rvalid_o, bus0.data_rdata_o};
      exp = {vecs[i].mreq, vecs[i].mwe, vecs[i].mbe, vecs[i].maddr, vecs[i].mwdata,
             vecs[i].irv, vecs[i].irdata, vecs[i].drv, vecs[i].drdata};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL vec[%0d]: got %h expected %h", i, act, exp);
      end
      next_cyc();
    end

    // Spurious gnt/rvalid while idle are ignored
    idle0();
    bus0.mem_gnt_i = 1'b1;
    bus0.mem_rvalid_i = 1'b1;
    bus0.mem_rdata_i = 32'hFFFF;
    @(negedge clk);
    chk("spurious_rvalids", {bus0.instr_rvalid_o, bus0.data_rvalid_o}, 64'd0);
    chk("spurious_rdata", 64'(bus0.data_rdata_o), 64'd0);
    next_cyc();
    idle0();
    @(negedge clk);
    chk("spurious_stay_idle", 64'(state0), 64'd0);
    next_cyc();

    // Abort: fetch drops req while still ungranted
    bus0.instr_req_i = 1'b1;
    bus0.instr_addr_i = 32'h180;
    next_cyc();
    @(negedge clk);
    chk("abort_req_high", {bus0.mem_req_o, bus0.mem_addr_o}, {1'b1, 32'h180});
    next_cyc();
    bus0.instr_req_i = 1'b0;
    next_cyc();
    @(negedge clk);
    chk("abort_req_low", 64'(bus0.mem_req_o), 64'd0);
    chk("abort_idle", 64'(state0), 64'd0);
    chk("abort_addr_clr", 64'(bus0.mem_addr_o), 64'd0);
    next_cyc();
    @(negedge clk);
    chk("abort_no_rvalid", {bus0.mem_req_o, bus0.instr_rvalid_o}, 64'd0);
    next_cyc();

    // Discard: granted fetch abandoned in WAIT; later re-request at 0x300 completes
    bus0.instr_req_i = 1'b1;
    bus0.instr_addr_i = 32'h1C0;
    next_cyc();
    bus0.mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("disc_issue", {bus0.mem_req_o, bus0.mem_addr_o}, {1'b1, 32'h1C0});
    next_cyc();
    bus0.mem_gnt_i = 1'b0;
    bus0.instr_req_i = 1'b0;
    @(negedge clk);
    chk("disc_wait", 64'(state0), 64'd2);
    next_cyc();
    bus0.instr_req_i = 1'b1;
    bus0.instr_addr_i = 32'h300;
    bus0.mem_rvalid_i = 1'b1;
    bus0.mem_rdata_i = 32'h12345678;
    @(negedge clk);
    chk("disc_dropped", {bus0.instr_rvalid_o, bus0.instr_rdata_o}, 64'd0);
    next_cyc();
    bus0.mem_rvalid_i = 1'b0;
    next_cyc();
    bus0.mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("fresh_issue", {bus0.mem_req_o, bus0.mem_we_o, bus0.mem_addr_o}, {1'b1, 1'b0, 32'h300});
    next_cyc();
    bus0.mem_gnt_i = 1'b0;
    next_cyc();
    bus0.mem_rvalid_i = 1'b1;
    bus0.mem_rdata_i = 32'hABCD0300;
    @(negedge clk);
    chk("fresh_resp", {bus0.instr_rvalid_o, bus0.instr_rdata_o}, {1'b1, 32'hABCD0300});
    next_cyc();
    idle0();
    @(negedge clk);
    chk("fresh_done", {state0, bus0.instr_rvalid_o}, 64'd0);
    next_cyc();

    // Asynchronous reset in the middle of a data read
    bus0.data_req_i = 1'b1;
    bus0.data_be_i = 4'hF;
    bus0.data_addr_i = 32'h500;
    next_cyc();
    bus0.mem_gnt_i = 1'b1;
    next_cyc();
    bus0.mem_gnt_i = 1'b0;
    bus0.data_addr_i = 32'h40;
    bus0.mem_rvalid_i = 1'b1;
    bus0.mem_rdata_i = 32'hBAD0;
    #2;
    arstn = 1'b0;
    #1;
    chk("arst_state", 64'(state0), 64'd0);
    chk("arst_mem", {bus0.mem_req_o, bus0.mem_we_o, bus0.mem_be_o, bus0.mem_addr_o}, 64'd0);
    chk("arst_resp", {bus0.data_rvalid_o, bus0.data_rdata_o}, 64'd0);
    next_cyc();
    arstn = 1'b1;
    @(negedge clk);
    chk("stale_rvalid_ignored", {bus0.data_rvalid_o, bus0.data_rdata_o}, 64'd0);
    next_cyc();
    bus0.mem_rvalid_i = 1'b0;
    bus0.mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("post_rst_issue", {bus0.mem_req_o, bus0.mem_we_o, bus0.mem_addr_o}, {1'b1, 1'b0, 32'h40});
    next_cyc();
    bus0.mem_gnt_i = 1'b0;
    next_cyc();
    bus0.mem_rvalid_i = 1'b1;
    bus0.mem_rdata_i = 32'h11223344;
    @(negedge clk);
    chk("post_rst_resp", {bus0.data_rvalid_o, bus0.data_rdata_o, bus0.instr_rvalid_o},
        {1'b1, 32'h11223344, 1'b0});
    next_cyc();
    idle0();

    // Round-robin on instance 1: data first because last-served resets to instr
    exp_q.push_back(32'h2000);
    exp_q.push_back(32'h1000);
    exp_q.push_back(32'h2000);
    exp_q.push_back(32'h1000);
    rr_run = 1'b1;
    for (int k = 0; k < 200 && rr_issues < 4; k++) @(negedge clk);
    rr_run = 1'b0;
    chk("rr_issue_count", 64'(rr_issues), 64'd4);
    repeat (10) @(negedge clk);
    chk("rr_no_extra", 64'(rr_issues), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
